// File: rtl/avg_pool1d_pkg.sv
// Shared types and elaboration-time helpers for the streaming 1-D average pool.
package avg_pool1d_pkg;

  typedef enum logic [1:0] {
    STREAM,
    TAIL,
    FLUSH
  } state_t;

  // Number of complete windows produced per frame.
  function automatic int f_lout(int l, int k, int s, int pad);
    return (l + 2 * pad - k) / s + 1;
  endfunction

  // Running-sum width: input width plus growth for K terms plus a guard bit.
  function automatic int f_acc_w(int prec, int k);
    return prec + $clog2(k) + 1;
  endfunction

  // Reciprocal of K with recipBits fraction bits, rounded to nearest.
  function automatic int f_recip(int k, int recipBits);
    return ((1 << recipBits) + k / 2) / k;
  endfunction

endpackage

// File: rtl/avg_pool1d_lane.sv
// One channel: K-deep window, running sum, and rounded/saturated multiply by 1/K.
module avg_pool1d_lane
  import avg_pool1d_pkg::*;
#(
  parameter int W  = 8,
  parameter int K  = 3,
  parameter int RB = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_i,
  input  logic                clear_i,
  input  logic signed [W-1:0] sample_i,
  output logic signed [W-1:0] avg_o
);

  localparam int ACC_W  = f_acc_w(W, K);
  localparam int PROD_W = ACC_W + RB + 2;
  localparam int RES_W  = PROD_W - RB;

  localparam logic signed [PROD_W-1:0] RECIP_C = PROD_W'(f_recip(K, RB));
  localparam logic signed [PROD_W-1:0] HALF    = PROD_W'(1 << (RB - 1));
  localparam logic signed [RES_W-1:0]  SAT_MAX = RES_W'((1 << (W - 1)) - 1);
  localparam logic signed [RES_W-1:0]  SAT_MIN = RES_W'(-(1 << (W - 1)));

  logic signed [W-1:0]      win_q [K];
  logic signed [W-1:0]      win_d [K];
  logic signed [ACC_W-1:0]  acc_q, acc_d, accNext;
  logic signed [PROD_W-1:0] prod, rounded;
  logic signed [RES_W-1:0]  shifted;

  // Sum after the incoming sample enters and the oldest leaves, then scale by 1/K with half-up rounding.
  always_comb begin
    accNext = acc_q + ACC_W'(sample_i) - ACC_W'(win_q[K-1]);
    prod    = PROD_W'(accNext) * RECIP_C;
    rounded = prod + HALF;
    shifted = RES_W'(rounded >>> RB);
    if (shifted > SAT_MAX) begin
      avg_o = W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      avg_o = W'(SAT_MIN);
    end else begin
      avg_o = W'(shifted);
    end
  end

  // Window/accumulator next state: clear between frames, shift on each accepted position.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < K; i++) begin
      win_d[i] = win_q[i];
    end
    if (clear_i) begin
      acc_d = '0;
      for (int i = 0; i < K; i++) begin
        win_d[i] = '0;
      end
    end else if (shift_i) begin
      acc_d    = accNext;
      win_d[0] = sample_i;
      for (int i = 1; i < K; i++) begin
        win_d[i] = win_q[i-1];
      end
    end
  end

  // Window and accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      for (int i = 0; i < K; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      for (int i = 0; i < K; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

endmodule

// File: rtl/avg_pool1d_stream.sv
// Streaming channel-parallel 1-D average pool: FSM, position counters and output handshake.
module avg_pool1d_stream
  import avg_pool1d_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 8,
  parameter int DATA_IN_0_PRECISION_1       = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 16,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int KERNEL_SIZE                 = 3,
  parameter int STRIDE                      = 2,
  parameter int PADDING                     = 1,
  parameter int RECIP_BITS                  = 16,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0-1:0][DATA_IN_0_PRECISION_0-1:0] data_in_0,
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0-1:0][DATA_IN_0_PRECISION_0-1:0] data_out_0,
  output logic data_out_0_valid,
  input  logic data_out_0_ready
);

  localparam int W    = DATA_IN_0_PRECISION_0;
  localparam int P    = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int L    = DATA_IN_0_TENSOR_SIZE_DIM_0;
  localparam int K    = KERNEL_SIZE;
  localparam int S    = STRIDE;
  localparam int PAD  = PADDING;
  localparam int LOUT = f_lout(L, K, S, PAD);

  localparam int X_W  = (L > 1) ? $clog2(L) : 1;
  localparam int V_W  = $clog2(L + 2 * PAD + 1);
  localparam int WC_W = $clog2(LOUT + 1);
  localparam int PH_W = (S > 1) ? $clog2(S) : 1;
  localparam int T_W  = (PAD > 1) ? $clog2(PAD) : 1;

  localparam logic [X_W-1:0]  X_LAST  = X_W'(L - 1);
  localparam logic [V_W-1:0]  V_START = V_W'(PAD);
  localparam logic [V_W-1:0]  V_FIRST = V_W'(K - 1);
  localparam logic [WC_W-1:0] WC_LOUT = WC_W'(LOUT);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(S - 1);
  localparam logic [T_W-1:0]  T_LAST  = T_W'((PAD > 0) ? PAD - 1 : 0);

  if (DATA_OUT_0_PRECISION_0 != DATA_IN_0_PRECISION_0 ||
      DATA_OUT_0_PRECISION_1 != DATA_IN_0_PRECISION_1) begin : gPrecisionCheck
    $error("avg_pool1d_stream: output precision must match input precision");
  end

  state_t            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [V_W-1:0]    v_q, v_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [WC_W-1:0]   winCount_q, winCount_d;
  logic [T_W-1:0]    tail_q, tail_d;
  logic [P-1:0][W-1:0] out_q, out_d;
  logic              valid_q, valid_d;

  logic              slotFree, inReady, shift, windowDone, laneClear;
  logic [P-1:0][W-1:0] laneAvg;
  logic signed [W-1:0] laneSample [P];

  for (genvar i = 0; i < P; i++) begin : gLane
    assign laneSample[i] = (state_q == TAIL) ? '0 : data_in_0[i];

    avg_pool1d_lane #(
      .W (W),
      .K (K),
      .RB(RECIP_BITS)
    ) uLane (
      .clk     (clk),
      .rst     (rst),
      .shift_i (shift),
      .clear_i (laneClear),
      .sample_i(laneSample[i]),
      .avg_o   (laneAvg[i])
    );
  end

  // Handshake and window-completion decode; a shift only happens when the output slot can take a result.
  always_comb begin
    slotFree   = !valid_q || data_out_0_ready;
    inReady    = (state_q == STREAM) && slotFree && !rst;
    shift      = ((state_q == STREAM) && data_in_0_valid && inReady) ||
                 ((state_q == TAIL) && slotFree);
    windowDone = shift && (v_q >= V_FIRST) && (phase_q == '0) && (winCount_q < WC_LOUT);
    laneClear  = (state_q == FLUSH);
  end

  // Next state for the FSM, position/stride/window counters and the output register.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    v_d        = v_q;
    phase_d    = phase_q;
    winCount_d = winCount_q;
    tail_d     = tail_q;
    out_d      = out_q;
    valid_d    = valid_q;

    case (state_q)
      STREAM: begin
        if (shift) begin
          x_d = x_q + 1'b1;
          if (x_q == X_LAST) begin
            state_d = (PAD > 0) ? TAIL : FLUSH;
          end
        end
      end
      TAIL: begin
        if (shift) begin
          tail_d = tail_q + 1'b1;
          if (tail_q == T_LAST) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        x_d        = '0;
        tail_d     = '0;
        v_d        = V_START;
        phase_d    = '0;
        winCount_d = '0;
        state_d    = STREAM;
      end
      default: state_d = STREAM;
    endcase

    if (shift) begin
      v_d = v_q + 1'b1;
      if (v_q >= V_FIRST) begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      end
    end

    if (windowDone) begin
      winCount_d = winCount_q + 1'b1;
      out_d      = laneAvg;
      valid_d    = 1'b1;
    end else if (data_out_0_ready) begin
      valid_d = 1'b0;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STREAM;
      x_q        <= '0;
      v_q        <= V_START;
      phase_q    <= '0;
      winCount_q <= '0;
      tail_q     <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      v_q        <= v_d;
      phase_q    <= phase_d;
      winCount_q <= winCount_d;
      tail_q     <= tail_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_in_0_ready  = inReady;
  assign data_out_0       = out_q;
  assign data_out_0_valid = valid_q;

endmodule

// File: tb/tb_avg_pool1d_stream.sv
// Scoreboard bench for avg_pool1d_stream across three kernel/stride/padding configurations.
module tb_avg_pool1d_stream;

  localparam int W    = 8;
  localparam int FB   = 3;
  localparam int L    = 16;
  localparam int P    = 4;
  localparam int RB   = 16;
  localparam int NDUT = 3;

  typedef logic [P*W-1:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [P-1:0][W-1:0] inData   [NDUT];
  logic                inValid  [NDUT];
  logic                inReady  [NDUT];
  logic [P-1:0][W-1:0] outData  [NDUT];
  logic                outValid [NDUT];

  int    readyMode   [NDUT];
  int    xferCount   [NDUT];
  int    firstAccept [NDUT];
  int    lastAccept  [NDUT];
  beat_t expQ        [NDUT][$];

  logic signed [W-1:0] frameBuf [L][P];

  int cycle  = 0;
  int checks = 0;
  int errors = 0;

  function automatic int kOf(int g);
    return (g == 0) ? 3 : ((g == 1) ? 4 : 1);
  endfunction
  function automatic int sOf(int g);
    return (g == 0) ? 2 : ((g == 1) ? 4 : 1);
  endfunction
  function automatic int padOf(int g);
    return (g == 0) ? 1 : 0;
  endfunction
  function automatic int loutOf(int g);
    return (L + 2 * padOf(g) - kOf(g)) / sOf(g) + 1;
  endfunction

  task automatic checkOutput(input string name, input int g, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL dut%0d %s actual=%h required=%h (t=%0t)", g, name, act, exp, $time);
    end
  endtask

  // Reference: average each K-position window of the zero-padded sequence, round half-up, saturate.
  function automatic void pushExpected(int g, int nWin);
    int     k     = kOf(g);
    int     s     = sOf(g);
    int     pad   = padOf(g);
    int     lout  = loutOf(g);
    longint recip = longint'($floor((2.0 ** RB) / k + 0.5));
    for (int j = 0; j < lout; j++) begin
      beat_t b = '0;
      if (nWin >= 0 && j >= nWin) break;
      for (int p = 0; p < P; p++) begin
        longint sum = 0;
        longint q;
        for (int t = 0; t < k; t++) begin
          int pos = j * s + t - pad;
          if (pos >= 0 && pos < L) sum += longint'(frameBuf[pos][p]);
        end
        q = (sum * recip + (longint'(1) << (RB - 1))) >>> RB;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        b[p*W +: W] = W'(q);
      end
      expQ[g].push_back(b);
    end
  endfunction

  function automatic int partialWindows(int g, int nBeats);
    int n = 0;
    for (int j = 0; j < loutOf(g); j++) begin
      if (j * sOf(g) + kOf(g) - 1 <= padOf(g) + nBeats - 1) n++;
    end
    return n;
  endfunction

  task automatic fillFrame(input int mode);
    for (int x = 0; x < L; x++) begin
      for (int p = 0; p < P; p++) begin
        case (mode)
          0: frameBuf[x][p] = W'(p * 8);
          1: begin
            case (p)
              0: frameBuf[x][p] = (x < 2) ? W'(1) : W'(0);
              1: frameBuf[x][p] = (x < 2) ? W'(-1) : W'(0);
              2: frameBuf[x][p] = W'(127);
              default: frameBuf[x][p] = W'(-128);
            endcase
          end
          3: frameBuf[x][p] = W'(-128);
          default: begin
            if ($urandom_range(0, 7) == 0) frameBuf[x][p] = ($urandom_range(0, 1) == 0) ? W'(127) : W'(-128);
            else frameBuf[x][p] = W'($urandom);
          end
        endcase
      end
    end
  endtask

  task automatic printSummary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  task automatic applyStimulus(input int g, input int nBeats, input int gapPct);
    for (int x = 0; x < nBeats; x++) begin
      int waitCycles = 0;
      bit accepted   = 1'b0;
      if (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
        inValid[g] = 1'b0;
        @(posedge clk);
        #1;
      end
      for (int p = 0; p < P; p++) inData[g][p] = frameBuf[x][p];
      inValid[g] = 1'b1;
      while (!accepted) begin
        @(negedge clk);
        accepted = inReady[g];
        @(posedge clk);
        #1;
        waitCycles++;
        if (!accepted && waitCycles > 300) begin
          checks++;
          errors++;
          $display("[TB] FAIL dut%0d input_accept_timeout beat=%0d actual=stalled required=accepted", g, x);
          printSummary();
          $fatal(1, "[TB] input never accepted");
        end
      end
      if (x == 0) firstAccept[g] = cycle;
      lastAccept[g] = cycle;
    end
    inValid[g] = 1'b0;
  endtask

  function automatic bit anyPending();
    for (int g = 0; g < NDUT; g++) if (expQ[g].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic waitDrain();
    int n = 0;
    while (anyPending() && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    for (int g = 0; g < NDUT; g++) checkOutput("queue_empty", g, 64'(expQ[g].size()), 64'd0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    localparam int KK = (g == 0) ? 3 : ((g == 1) ? 4 : 1);
    localparam int SS = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    localparam int PP = (g == 0) ? 1 : 0;

    logic outRdy;

    avg_pool1d_stream #(
      .DATA_IN_0_PRECISION_0      (W),
      .DATA_IN_0_PRECISION_1      (FB),
      .DATA_IN_0_TENSOR_SIZE_DIM_0(L),
      .DATA_IN_0_PARALLELISM_DIM_0(P),
      .KERNEL_SIZE                (KK),
      .STRIDE                     (SS),
      .PADDING                    (PP),
      .RECIP_BITS                 (RB),
      .DATA_OUT_0_PRECISION_0     (W),
      .DATA_OUT_0_PRECISION_1     (FB)
    ) uDut (
      .clk             (clk),
      .rst             (rst),
      .data_in_0       (inData[g]),
      .data_in_0_valid (inValid[g]),
      .data_in_0_ready (inReady[g]),
      .data_out_0      (outData[g]),
      .data_out_0_valid(outValid[g]),
      .data_out_0_ready(outRdy)
    );

    // Downstream ready pattern: always ready, random, or held low.
    initial begin
      outRdy = 1'b1;
      forever begin
        @(posedge clk);
        #2;
        case (readyMode[g])
          0: outRdy = 1'b1;
          1: outRdy = ($urandom_range(0, 99) < 60);
          default: outRdy = 1'b0;
        endcase
      end
    end

    // Monitor: pop and compare on every transfer, and check hold behaviour while stalled.
    initial begin
      beat_t exp;
      beat_t held;
      bit    heldFlag;
      heldFlag = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          heldFlag = 1'b0;
        end else begin
          if (heldFlag) begin
            checkOutput("hold_valid", g, 64'(outValid[g]), 64'd1);
            checkOutput("hold_data", g, 64'(outData[g]), 64'(held));
          end
          heldFlag = 1'b0;
          if (outValid[g] && outRdy) begin
            xferCount[g]++;
            if (expQ[g].size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL dut%0d unexpected_output actual=%h required=none", g, outData[g]);
            end else begin
              exp = expQ[g].pop_front();
              checkOutput("output_beat", g, 64'(outData[g]), 64'(exp));
            end
          end else if (outValid[g]) begin
            checkOutput("stall_in_ready", g, 64'(inReady[g]), 64'd0);
            held     = outData[g];
            heldFlag = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cycle++;
    end
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    printSummary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int x0;
    int lastA;
    for (int g = 0; g < NDUT; g++) begin
      inValid[g]   = 1'b0;
      inData[g]    = '0;
      readyMode[g] = 0;
      xferCount[g] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput("reset_valid", g, 64'(outValid[g]), 64'd0);
      checkOutput("reset_data", g, 64'(outData[g]), 64'd0);
      checkOutput("reset_in_ready", g, 64'(inReady[g]), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) checkOutput("ready_after_reset", g, 64'(inReady[g]), 64'd1);
    @(posedge clk);
    #1;

    $display("[TB] basic sliding window");
    fillFrame(0); pushExpected(0, -1); applyStimulus(0, L, 0); waitDrain();

    $display("[TB] rounding and saturation");
    fillFrame(1); pushExpected(0, -1); applyStimulus(0, L, 0); waitDrain();

    $display("[TB] random frames with random ready");
    readyMode[0] = 1;
    for (int f = 0; f < 3; f++) begin
      fillFrame(2); pushExpected(0, -1); applyStimulus(0, L, 30);
    end
    waitDrain();

    $display("[TB] backpressure hold");
    readyMode[0] = 0;
    fillFrame(2); pushExpected(0, -1);
    fork
      applyStimulus(0, L, 0);
      begin
        repeat (6) @(posedge clk);
        readyMode[0] = 2;
        repeat (5) @(posedge clk);
        readyMode[0] = 1;
      end
    join
    waitDrain();
    readyMode[0] = 0;

    $display("[TB] stride equals kernel");
    fillFrame(2); pushExpected(1, -1); applyStimulus(1, L, 0);
    readyMode[1] = 1;
    fillFrame(2); pushExpected(1, -1); applyStimulus(1, L, 20);
    waitDrain();
    readyMode[1] = 0;

    $display("[TB] kernel of one passthrough");
    fillFrame(3); pushExpected(2, -1); applyStimulus(2, L, 0);
    readyMode[2] = 1;
    fillFrame(2); pushExpected(2, -1); applyStimulus(2, L, 25);
    waitDrain();
    readyMode[2] = 0;

    $display("[TB] reset mid-frame");
    fillFrame(2); pushExpected(0, partialWindows(0, 7)); applyStimulus(0, 7, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_cycle_in_ready", 0, 64'(inReady[0]), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("post_rst_valid", 0, 64'(outValid[0]), 64'd0);
    checkOutput("post_rst_data", 0, 64'(outData[0]), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fillFrame(0); pushExpected(0, -1); applyStimulus(0, L, 0); waitDrain();

    $display("[TB] back-to-back frames");
    for (int g = 0; g < 2; g++) begin
      x0 = xferCount[g];
      fillFrame(2); pushExpected(g, -1); applyStimulus(g, L, 0);
      lastA = lastAccept[g];
      fillFrame(2); pushExpected(g, -1); applyStimulus(g, L, 0);
      checkOutput("frame_gap", g, 64'(firstAccept[g] - lastA), 64'(padOf(g) + 2));
      waitDrain();
      checkOutput("b2b_count", g, 64'(xferCount[g] - x0), 64'(2 * loutOf(g)));
    end

    repeat (10) @(posedge clk);
    printSummary();
    $finish;
  end

endmodule

// File: doc/avg_pool1d_stream.md
Name: avg_pool1d_stream

Overview:
Streaming, channel-parallel 1-D average pool with true sliding-window state, stride, zero padding and fixed-point rounding/saturation. Each lane carries an independent channel. Positions arrive one beat at a time, and one averaged output beat is emitted per completed window. The block sits between conv/activation stages on the standard valid/ready dataflow interface and replaces the combinational single-beat pool wherever windows span beats.

Parameters:
- DATA_IN_0_PRECISION_0, 8: total bits, signed two's complement.
- DATA_IN_0_PRECISION_1, 3: fractional bits, carried through unchanged.
- DATA_IN_0_TENSOR_SIZE_DIM_0, 16: sequence length L per frame.
- DATA_IN_0_PARALLELISM_DIM_0, 4: lanes P (channels per beat).
- KERNEL_SIZE, 3: window K, 1..L+2*PADDING.
- STRIDE, 2: window step S, 1..K.
- PADDING, 1: zero positions at each end, 0..K-1.
- RECIP_BITS, 16: fraction bits of the 1/K reciprocal constant.
- DATA_OUT_0_PRECISION_0 / _1: must equal the input values; checked by an elaboration assertion.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- data_in_0, in, [P][PREC_0]: one position, P channels.
- data_in_0_valid, in, 1: input beat valid.
- data_in_0_ready, out, 1: input beat accepted when valid && ready.
- data_out_0, out, [P][PREC_0]: averaged window, registered.
- data_out_0_valid, out, 1: output beat valid.
- data_out_0_ready, in, 1: downstream accept.

Behaviour:
- Derived constants:
  - LOUT = (L + 2*PADDING - K)/S + 1, integer division.
  - ACC_W = PREC_0 + clog2(K) + 1.
  - RECIP = round(2^RECIP_BITS / K).
- Per-lane state: K-entry shift register win[] plus running sum acc (ACC_W bits, signed).
  - On every shift: acc <= acc + new - win[K-1].
- Leading padding is implicit: win and acc are zero at frame start.
- Virtual index v counts shifted positions from PADDING up to L+2*PADDING-1.
- FSM states:
  - STREAM: accept real inputs.
    - data_in_0_ready = (state==STREAM) && (!data_out_0_valid || data_out_0_ready).
    - On the accepted beat with x == L-1: go to TAIL if PADDING > 0, else to FLUSH.
  - TAIL: inject zero positions, one per cycle when the output slot is free. Input ready is held at 0. After PADDING injections, go to FLUSH.
  - FLUSH: one cycle. Clear win, acc, counters and v to PADDING. Return to STREAM.
- Window completion: when the shifted position has v >= K-1, (v-(K-1)) % S == 0 and the window count is below LOUT.
  - The modulo is tracked with a stride phase counter; no divider is used.
- Output arithmetic, applied to acc_next, the acc value after the shift that completes the window:
  - prod = acc_next * RECIP.
  - Add 2^(RECIP_BITS-1), then arithmetic shift right by RECIP_BITS (round-half-up).
  - Saturate to a signed PREC_0 range.
  - Register into data_out_0 and set data_out_0_valid the same edge. Latency is 1 cycle from the completing beat.
- data_out_0_valid stays high with data stable until data_out_0_ready is high.
  - A new window may complete on the same edge the old one is consumed, giving back-to-back output.
- Positions past the last window (v beyond LOUT coverage) are shifted but produce no output.
- On rst, all of the following are cleared; rst mid-frame discards the partial frame:
  - data_out_0_valid = 0, data_out_0 = 0, data_in_0_ready = 0 in the reset cycle.
  - win, acc and counters = 0, state = STREAM, v = PADDING.
- Throughput: 1 position per cycle in STREAM when the output is unstalled. TAIL adds PADDING cycles and FLUSH adds 1 cycle per frame.

Decomposition:
- Package avg_pool1d_pkg holds:
  - Functions: f_lout(L, K, S, PAD), f_acc_w(PREC, K), f_recip(K, RECIP_BITS).
  - A state_t enum {STREAM, TAIL, FLUSH}.
- Sub-module avg_pool1d_lane holds one lane's window shift register, running accumulator and rounding/saturating reciprocal multiply.
  - The top instantiates P lanes.
  - The top owns the FSM, the position/stride/window counters and the output handshake.

Test Plan:
- Basic sliding window. Config: L=16, P=4, K=3, S=2, PAD=1, fraction 3. Stimulus: lane i = constant i*8 (value i.0). Required: 8 outputs per frame; interior windows = i*8; the first window = round(2*i*8/3) (padding counted); no output after the 8th.
- Rounding and saturation.
  - K=3, window {1,1,0} raw must give round(2/3) = 1.
  - Window {-1,-1,0} must give -1 (half-up on negative).
  - K=1 passthrough at -128 must give -128 unchanged.
- Backpressure. Hold data_out_0_ready low 5 cycles mid-frame. Required: data_in_0_ready low, data_out_0 stable, no beat lost or duplicated versus the golden model over a random ready pattern.
- Stride equal to kernel. K=S=4, PAD=0, L=16. Required: 4 non-overlapping averages, exact match to the golden model, FLUSH then a second frame correct.
- Reset mid-frame. Assert rst after 7 inputs. Required:
  - Next cycle: valid=0, ready=0.
  - The following frame's first window ignores the pre-reset data.
- Back-to-back frames under continuous valid and ready=1. Required: the output count equals 2*LOUT and TAIL/FLUSH bubbles equal PADDING+1 cycles per frame.
